// File: rtl/instrumented_adder_sampler.sv
// Instrumented adder sampler: counts rising edges of the adder's asynchronous
// chain output over a programmed window of wb_clk_i cycles, then publishes
// the edge count, a done flag and an overflow flag to the logic analyser.
//
// Optional build macro: SAMPLER_SATURATE_EN
//   defined   - the edge accumulator saturates at all-ones; overflow flags an
//               edge that arrives while the accumulator is already at max.
//   undefined - the accumulator wraps modulo 2^CNT_W; overflow flags the wrap.
module instrumented_adder_sampler #(
   parameter int CNT_W    = 32,
   parameter int WIN_W    = 32,
   parameter int SYNC_LEN = 2
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n,
   input  logic             chain_in,
   input  logic             start,
   input  logic             abort,
   input  logic [WIN_W-1:0] window,
   output logic [CNT_W-1:0] count,
   output logic             done,
   output logic             busy,
   output logic             overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [SYNC_LEN-1:0] sync_q;
   logic                sync_prev;
   logic                start_d;
   logic                start_rise;
   logic                edge_pulse;
   logic [WIN_W-1:0]    win_q;
   logic [WIN_W-1:0]    timer;
   logic [CNT_W-1:0]    acc;

   assign edge_pulse = sync_q[SYNC_LEN-1] & ~sync_prev;
   assign start_rise = start & ~start_d;
   assign busy       = (state_q == ARM) || (state_q == COUNT);

   // Synchronise the chain output, keep its previous value for edge
   // detection, and remember the last start level for rise detection.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) begin
         sync_q    <= '0;
         sync_prev <= 1'b0;
         start_d   <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_LEN-2:0], chain_in};
         sync_prev <= sync_q[SYNC_LEN-1];
         start_d   <= start;
      end
   end

   // State register.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort wins over everything, including a start rise.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start_rise) state_d = ARM;
            ARM:     state_d = COUNT;
            COUNT:   if (timer == WIN_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Measurement datapath: arm, count edges while the timer runs, publish.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) begin
         win_q    <= '0;
         timer    <= '0;
         acc      <= '0;
         count    <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else if (!abort) begin
         case (state_q)
            IDLE: begin
               if (start_rise) begin
                  done     <= 1'b0;
                  overflow <= 1'b0;
                  acc      <= '0;
                  win_q    <= (window == '0) ? WIN_W'(1) : window;
               end
            end
            ARM: begin
               timer <= win_q;
            end
            COUNT: begin
               timer <= timer - WIN_W'(1);
               if (edge_pulse) begin
`ifdef SAMPLER_SATURATE_EN
                  if (acc == '1) begin
                     overflow <= 1'b1;
                  end else begin
                     acc <= acc + CNT_W'(1);
                  end
`else
                  acc <= acc + CNT_W'(1);
                  if (acc == '1) begin
                     overflow <= 1'b1;
                  end
`endif
               end
            end
            DONE: begin
               count <= acc;
               done  <= 1'b1;
            end
            default: begin
               timer <= timer;
            end
         endcase
      end
   end

endmodule
